// File: rtl/hyperbus_arbiter.sv
// Round-robin arbiter sharing one HyperBus primary controller between NPORTS requesters.
// Optional watchdog enabled by defining HYPERBUS_ARB_TIMEOUT_EN.
module hyperbus_arbiter #(
  parameter int NPORTS         = 2,
  parameter int WIDTH          = 8,
  parameter int TIMEOUT_CYCLES = 255,
  localparam int GW            = (NPORTS > 2) ? $clog2(NPORTS) : 1,
  localparam int DW            = 2 * WIDTH
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NPORTS-1:0]    req_rrq,
  input  logic [NPORTS-1:0]    req_wrq,
  input  logic [NPORTS-1:0]    req_reg_space,
  input  logic [NPORTS*32-1:0] req_adr,
  input  logic [NPORTS*DW-1:0] req_dat,
  output logic [NPORTS-1:0]    req_ack,
  output logic                 req_err,
  output logic [DW-1:0]        rdata,
  output logic [GW-1:0]        grant,
  output logic [31:0]          hb_adr,
  output logic [DW-1:0]        hb_dat_o,
  output logic                 hb_reg_space,
  output logic                 hb_rrq,
  output logic                 hb_wrq,
  input  logic [DW-1:0]        hb_dat_i,
  input  logic                 hb_busy,
  input  logic                 hb_error
);

  localparam int unsigned NP = NPORTS;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [GW-1:0]      ptr_q, ptr_d;
  logic [GW-1:0]      grant_q, grant_d;
  logic [31:0]        adr_q, adr_d;
  logic [DW-1:0]      dat_q, dat_d;
  logic               reg_q, reg_d;
  logic               rrq_q, rrq_d;
  logic               wrq_q, wrq_d;
  logic [NPORTS-1:0]  ack_q, ack_d;
  logic               err_q, err_d;
  logic [DW-1:0]      rdata_q, rdata_d;

  logic [NPORTS-1:0]  active;
  logic [31:0]        adr_arr [NPORTS];
  logic [DW-1:0]      dat_arr [NPORTS];
  logic               found;
  logic [GW-1:0]      win;
  logic               timeout_hit;

  assign active = req_rrq | req_wrq;

  for (genvar g = 0; g < NPORTS; g++) begin : g_unpack
    assign adr_arr[g] = req_adr[32*g+31 : 32*g];
    assign dat_arr[g] = req_dat[DW*g+DW-1 : DW*g];
  end

`ifdef HYPERBUS_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q;

  // Cleared while IDLE, which is equivalent to clearing on entry to ISSUE.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                                        cnt_q <= '0;
    else if (state_q == S_IDLE)                       cnt_q <= '0;
    else if (state_q == S_ISSUE || state_q == S_WAIT) cnt_q <= cnt_q + 1'b1;
  end

  assign timeout_hit = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
  // Watchdog compiled out; expression is constant 0 for any legal limit.
  assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

  always_comb begin
    int unsigned idx;
    idx   = 0;
    found = 1'b0;
    win   = '0;
    for (int unsigned k = 1; k <= NP; k++) begin
      idx = (32'(ptr_q) + k) % NP;
      if (!found && active[GW'(idx)]) begin
        found = 1'b1;
        win   = GW'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    reg_d   = reg_q;
    rrq_d   = rrq_q;
    wrq_d   = wrq_q;
    rdata_d = rdata_q;
    ack_d   = '0;
    err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (found) begin
          grant_d = win;
          ptr_d   = win;
          adr_d   = adr_arr[win];
          dat_d   = dat_arr[win];
          reg_d   = req_reg_space[win];
          if (hb_error) begin
            state_d    = S_DONE;
            ack_d[win] = 1'b1;
            err_d      = 1'b1;
          end else begin
            state_d = S_ISSUE;
            rrq_d   = req_rrq[win];
            wrq_d   = ~req_rrq[win];
          end
        end
      end

      S_ISSUE: begin
        if (hb_error || timeout_hit) begin
          state_d        = S_DONE;
          ack_d[grant_q] = 1'b1;
          err_d          = 1'b1;
          rrq_d          = 1'b0;
          wrq_d          = 1'b0;
        end else if (hb_busy) begin
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (hb_error) begin
          state_d        = S_DONE;
          ack_d[grant_q] = 1'b1;
          err_d          = 1'b1;
          rrq_d          = 1'b0;
          wrq_d          = 1'b0;
        end else if (!hb_busy) begin
          state_d        = S_DONE;
          ack_d[grant_q] = 1'b1;
          rrq_d          = 1'b0;
          wrq_d          = 1'b0;
          if (rrq_q) rdata_d = hb_dat_i;
        end else if (timeout_hit) begin
          state_d        = S_DONE;
          ack_d[grant_q] = 1'b1;
          err_d          = 1'b1;
          rrq_d          = 1'b0;
          wrq_d          = 1'b0;
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      ptr_q   <= GW'(NPORTS - 1);
      grant_q <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      reg_q   <= 1'b0;
      rrq_q   <= 1'b0;
      wrq_q   <= 1'b0;
      ack_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      reg_q   <= reg_d;
      rrq_q   <= rrq_d;
      wrq_q   <= wrq_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign req_ack      = ack_q;
  assign req_err      = err_q;
  assign rdata        = rdata_q;
  assign grant        = grant_q;
  assign hb_adr       = adr_q;
  assign hb_dat_o     = dat_q;
  assign hb_reg_space = reg_q;
  assign hb_rrq       = rrq_q;
  assign hb_wrq       = wrq_q;

endmodule

// File: doc/hyperbus_arbiter.md
Name: hyperbus_arbiter

Overview:
- Shares one HyperBus primary controller between NPORTS requesters using round-robin arbitration.
- Latches the winning requester's address, write data and space select, then drives the controller's level-sensitive rrq/wrq.
- Holds the request until the controller's busy has risen and fallen, then returns read data and a one-cycle ack to the winner.
- Sits between system-side masters (e.g. bus bridge, DMA) and the controller, in the controller's clock domain.

Parameters:
- NPORTS, 2, number of requesters (2..8).
- WIDTH, 8, HyperBus DQ width; data words are 2*WIDTH bits.
- TIMEOUT_CYCLES, 255, watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  controller clock, all logic on posedge.
- rstn  in  1  asynchronous active-low reset.
- req_rrq  in  NPORTS  per-port read request, level, held until ack.
- req_wrq  in  NPORTS  per-port write request, level, held until ack.
- req_reg_space  in  NPORTS  per-port register-space select.
- req_adr  in  NPORTS*32  per-port address; port i at [32*i+31:32*i].
- req_dat  in  NPORTS*2*WIDTH  per-port write data, packed the same way.
- req_ack  out  NPORTS  one-hot, one-cycle completion pulse.
- req_err  out  1  qualifies req_ack; 1 means the transaction failed.
- rdata  out  2*WIDTH  read data, valid while req_ack is nonzero.
- grant  out  $clog2(NPORTS) (min 1)  index of the current or last granted port.
- hb_adr  out  32  to controller adr_i.
- hb_dat_o  out  2*WIDTH  to controller dat_i.
- hb_reg_space  out  1  to controller reg_space_i.
- hb_rrq  out  1  to controller rrq.
- hb_wrq  out  1  to controller wrq.
- hb_dat_i  in  2*WIDTH  from controller dat_o.
- hb_busy  in  1  from controller busy.
- hb_error  in  1  from controller error_o; sticky.

Behaviour:
- Reset: all outputs are registered and reset to 0 (req_ack, req_err, rdata, grant, hb_adr, hb_dat_o, hb_reg_space, hb_rrq, hb_wrq); the round-robin pointer resets to NPORTS-1, so port 0 has first priority. Asserting rstn mid-transaction aborts it, issues no ack, and the FSM returns to IDLE.
- Port i is active when req_rrq[i] | req_wrq[i]. If both are set, the transaction is a read.
- States are IDLE, ISSUE, WAIT and DONE.
- IDLE:
  - If any port is active, pick the first active port searching upward from pointer+1, modulo NPORTS.
  - Register grant, hb_adr, hb_dat_o, hb_reg_space, and one of hb_rrq/hb_wrq; set pointer to the granted port; go to ISSUE.
  - One-cycle latency from a request being sampled to hb_rrq/hb_wrq asserting.
  - If hb_error=1 in IDLE with a winner, skip ISSUE and go straight to DONE with err=1; hb_rrq/hb_wrq stay 0.
- ISSUE:
  - Hold the request outputs.
  - hb_busy=1 -> WAIT.
  - hb_error=1 -> DONE with err=1.
- WAIT:
  - Hold the request outputs.
  - hb_busy=0 -> DONE and clear hb_rrq/hb_wrq on the same edge, so the controller cannot restart during its idle cooldown.
  - hb_error=1 -> DONE with err=1, outputs cleared.
- DONE:
  - req_ack[grant]=1 and req_err are valid for exactly one cycle.
  - For reads, rdata = hb_dat_i sampled on the WAIT->DONE edge; for writes, rdata holds its previous value.
  - Next state is always IDLE.
- Requester contract: drop or change the request on the clock edge after ack. Requests are never re-sampled until IDLE.
  - A request dropped before ack is a protocol violation; the transaction still completes and acks that port.
- Fairness: with all ports continuously active, grants rotate 0,1,...,NPORTS-1,0. Any single active port wins within NPORTS transactions.
- Minimum spacing between transactions is IDLE+ISSUE+WAIT+DONE plus the controller's busy period.
- Request inputs and hb_busy are only read in the states above; they are assumed synchronous to clk.

Optional Feature:
- Macro HYPERBUS_ARB_TIMEOUT_EN.
- With the macro: a counter of $clog2(TIMEOUT_CYCLES+1) bits clears on entry to ISSUE and increments in ISSUE and WAIT.
  - Reaching TIMEOUT_CYCLES forces DONE with err=1 and clears hb_rrq/hb_wrq.
  - The counter resets to 0.
- Without the macro: no counter exists; ISSUE and WAIT wait indefinitely.

Test Plan:
- Port0 read, adr=0x0000_0010; bench controller raises busy 2 cycles after rrq and drops it 20 cycles later with hb_dat_i=0xA55A -> hb_adr=0x10 and hb_rrq=1 one cycle after request; hb_rrq=0 on busy fall; req_ack=2'b01, req_err=0, rdata=0xA55A for one cycle.
- Port1 write, adr=0x40, dat=0x1234 -> hb_wrq=1, hb_dat_o=0x1234, hb_adr=0x40; req_ack=2'b10 after busy falls; hb_rrq never asserted.
- Both ports held active for 4 transactions from reset -> grant sequence 0,1,0,1; each ack one-hot and one cycle wide.
- Port0 sets req_rrq=1 and req_wrq=1 together -> only hb_rrq asserts.
- hb_error rises during WAIT -> next cycle req_ack[grant]=1 with req_err=1 and hb_rrq=0; a later request while hb_error=1 acks with err=1 in 2 cycles and never asserts hb_rrq/hb_wrq.
- With HYPERBUS_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, busy never rises -> ack with err=1 exactly 16 cycles after ISSUE entry. Separately, rstn pulsed low during WAIT -> all outputs 0, no ack, and port 0 wins the next arbitration.
